alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked ALU with optional multi-cycle shift-add multiply (macro ALU_MC_MUL_EN)
//
// Operations 0-6 complete in a single cycle. Funct 7 behaves differently depending on the build:
// - When ALU_MC_MUL_EN is defined, it runs a shift-add multiply that takes WIDTH cycles in BUSY.
// - When ALU_MC_MUL_EN is undefined, it completes in a single cycle and returns zero.
module alu_mc #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Rs_data,
    input  logic [WIDTH-1:0] Rt_data,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       Funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Rd_data,
    output logic             Zero
);

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_SLL = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_SRL = 3'd4;
    localparam logic [2:0] F_AND = 3'd5;
    localparam logic [2:0] F_SLT = 3'd6;
    localparam logic [2:0] F_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MC_MUL_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] alu_result;
    logic             slt_bit;

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] mul_cand;
    logic [WIDTH-1:0] mul_plier;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_sum;
    logic [SHW-1:0]   iter_cnt;
    logic             mul_last;
`endif

    assign accept  = in_valid && in_ready;
    assign Rd_data = rd_q;
    assign Zero    = (rd_q == '0);
    assign slt_bit = ($signed(Rs_data) < $signed(Rt_data));

    // Single-cycle result computed straight from the live operands at the accepting edge.
    always_comb begin
        alu_result = '0;
        case (Funct)
            F_ADD:   alu_result = Rs_data + Rt_data;
            F_SUB:   alu_result = Rs_data - Rt_data;
            F_SLL:   alu_result = Rs_data << shamt;
            F_OR:    alu_result = Rs_data | Rt_data;
            F_SRL:   alu_result = Rs_data >> shamt;
            F_AND:   alu_result = Rs_data & Rt_data;
            F_SLT:   alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            F_MUL:   alu_result = '0;
            default: alu_result = '0;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    // One shift-add step: add the multiplicand when the current multiplier LSB is set.
    always_comb begin
        mul_sum  = mul_acc + (mul_plier[0] ? mul_cand : '0);
        mul_last = (iter_cnt == SHW'(WIDTH - 1));
    end
`endif

    // State register; reset wins over any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_MC_MUL_EN
                    if (Funct == F_MUL) begin
                        state_next = BUSY;
                    end else begin
                        state_next = DONE;
                    end
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef ALU_MC_MUL_EN
            BUSY: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result register and multiplier datapath; the result is only written on completion so it
    // holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= '0;
`ifdef ALU_MC_MUL_EN
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_acc   <= '0;
            iter_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_MC_MUL_EN
                        if (Funct == F_MUL) begin
                            mul_cand  <= Rs_data;
                            mul_plier <= Rt_data;
                            mul_acc   <= '0;
                            iter_cnt  <= '0;
                        end else begin
                            rd_q <= alu_result;
                        end
`else
                        rd_q <= alu_result;
`endif
                    end
                end
`ifdef ALU_MC_MUL_EN
                BUSY: begin
                    mul_acc   <= mul_sum;
                    mul_cand  <= mul_cand << 1;
                    mul_plier <= mul_plier >> 1;
                    if (mul_last) begin
                        rd_q     <= mul_sum;
                        iter_cnt <= '0;
                    end else begin
                        iter_cnt <= iter_cnt + SHW'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
